cycle_stat_ctrl: RTL and testbench

- Run/halt controller and event scheduler for the CPU's cycle-statistics counters.
- Tracks CPU execution state (idle, running, halted) and routes every executed cycle to exactly one class counter: jump, taken-branch or other. It also maintains a total-cycle count.
- Drives the board display through a select mux. Sits beside the CPU top, fed by decode/branch-resolve strobes and the halt (syscall) line.

---
 rtl/cycle_stat_ctrl.sv | 120 ++++++++++++
 tb/tb_cycle_stat_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cycle_stat_ctrl.sv
// Run/halt controller for the CPU cycle-statistics counters.
// Classifies every RUN cycle as jump, taken-branch or other, with saturating counts.
module cycle_stat_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             go,
    input  logic             halt,
    input  logic             jmp,
    input  logic             br_taken,
    input  logic             clr,
    input  logic [1:0]       sel,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] jmp_cnt,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] other_cnt,
    output logic [CNT_W-1:0] disp,
    output logic [1:0]       state,
    output logic             sat
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHalt = 2'b10,
        StBad  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] CntMax  = '1;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntZero = '0;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] jmp_q, jmp_d;
    logic [CNT_W-1:0] br_q, br_d;
    logic [CNT_W-1:0] other_q, other_d;
    logic             sat_q, sat_d;

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        jmp_d   = jmp_q;
        br_d    = br_q;
        other_d = other_q;
        sat_d   = sat_q;
        if (clr) begin
            state_d = StIdle;
            total_d = CntZero;
            jmp_d   = CntZero;
            br_d    = CntZero;
            other_d = CntZero;
            sat_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (go) state_d = StRun;
                end
                StRun: begin
                    // A counter at max holds its value and raises the sticky flag.
                    if (total_q == CntMax) sat_d = 1'b1;
                    else                   total_d = total_q + CntOne;
                    if (jmp) begin
                        if (jmp_q == CntMax) sat_d = 1'b1;
                        else                 jmp_d = jmp_q + CntOne;
                    end else if (br_taken) begin
                        if (br_q == CntMax) sat_d = 1'b1;
                        else                br_d = br_q + CntOne;
                    end else begin
                        if (other_q == CntMax) sat_d = 1'b1;
                        else                   other_d = other_q + CntOne;
                    end
                    if (halt) state_d = StHalt;
                end
                StHalt: begin
                    if (go) state_d = StRun;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            total_q <= '0;
            jmp_q   <= '0;
            br_q    <= '0;
            other_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            jmp_q   <= jmp_d;
            br_q    <= br_d;
            other_q <= other_d;
            sat_q   <= sat_d;
        end
    end

    always_comb begin
        disp = total_q;
        unique case (sel)
            2'b00:   disp = total_q;
            2'b01:   disp = jmp_q;
            2'b10:   disp = br_q;
            2'b11:   disp = other_q;
            default: disp = total_q;
        endcase
    end

    assign total_cnt = total_q;
    assign jmp_cnt   = jmp_q;
    assign br_cnt    = br_q;
    assign other_cnt = other_q;
    assign state     = state_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_cycle_stat_ctrl.sv
// Self-checking bench for cycle_stat_ctrl: 16-bit and 4-bit instances driven in lockstep
// and checked against a counting model, plus directed tables and sequences.
module tb_cycle_stat_ctrl;

    logic       clk = 1'b0;
    logic       RST = 1'b0;
    logic       go = 1'b0, halt = 1'b0, jmp = 1'b0, br_taken = 1'b0, clr = 1'b0;
    logic [1:0] sel = 2'b00;

    logic [15:0] t16, j16, b16, o16, d16;
    logic [1:0]  st16;
    logic        sat16;
    logic [3:0]  t4, j4, b4, o4, d4;
    logic [1:0]  st4;
    logic        sat4;

    always #5 clk = ~clk;

    cycle_stat_ctrl #(.CNT_W(16)) u16 (
        .clk(clk), .RST(RST), .go(go), .halt(halt), .jmp(jmp), .br_taken(br_taken),
        .clr(clr), .sel(sel), .total_cnt(t16), .jmp_cnt(j16), .br_cnt(b16),
        .other_cnt(o16), .disp(d16), .state(st16), .sat(sat16)
    );

    cycle_stat_ctrl #(.CNT_W(4)) u4 (
        .clk(clk), .RST(RST), .go(go), .halt(halt), .jmp(jmp), .br_taken(br_taken),
        .clr(clr), .sel(sel), .total_cnt(t4), .jmp_cnt(j4), .br_cnt(b4),
        .other_cnt(o4), .disp(d4), .state(st4), .sat(sat4)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: index 0 = 16-bit instance, 1 = 4-bit instance; counters total/jmp/br/other.
    int unsigned m_cnt[2][4];
    int unsigned m_max[2] = '{65535, 15};
    int          m_state[2];   // 0 idle, 1 run, 2 halt
    int unsigned m_sat[2];

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 4; k++) m_cnt[w][k] = 0;
            m_state[w] = 0;
            m_sat[w] = 0;
        end
    endfunction

    function automatic void bump(int w, int k);
        if (m_cnt[w][k] == m_max[w]) m_sat[w] = 1;
        else m_cnt[w][k] = m_cnt[w][k] + 1;
    endfunction

    function automatic void model_step(logic g, logic h, logic j, logic b, logic c);
        for (int w = 0; w < 2; w++) begin
            if (c) begin
                for (int k = 0; k < 4; k++) m_cnt[w][k] = 0;
                m_state[w] = 0;
                m_sat[w] = 0;
            end else if (m_state[w] == 1) begin
                bump(w, 0);
                bump(w, j ? 1 : (b ? 2 : 3));
                if (h) m_state[w] = 2;
            end else if (g) begin
                m_state[w] = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("u16.total", t16, m_cnt[0][0]);
        chk("u16.jmp", j16, m_cnt[0][1]);
        chk("u16.br", b16, m_cnt[0][2]);
        chk("u16.other", o16, m_cnt[0][3]);
        chk("u16.state", st16, m_state[0]);
        chk("u16.sat", sat16, m_sat[0]);
        chk("u16.disp", d16, m_cnt[0][int'(sel)]);
        chk("u4.total", t4, m_cnt[1][0]);
        chk("u4.jmp", j4, m_cnt[1][1]);
        chk("u4.br", b4, m_cnt[1][2]);
        chk("u4.other", o4, m_cnt[1][3]);
        chk("u4.state", st4, m_state[1]);
        chk("u4.sat", sat4, m_sat[1]);
        chk("u4.disp", d4, m_cnt[1][int'(sel)]);
    endtask

    task automatic step(input logic g, input logic h, input logic j, input logic b,
                        input logic c);
        go = g; halt = h; jmp = j; br_taken = b; clr = c;
        sel = 2'($urandom_range(0, 3));
        @(posedge clk);
        model_step(g, h, j, b, c);
        #1;
        compare_all();
    endtask

    typedef struct {
        logic g, h, j, b, c;
        int unsigned st, t, jc, bc, oc;
    } vec_t;

    function automatic vec_t mk(logic g, logic h, logic j, logic b, logic c,
                                int unsigned st, int unsigned t, int unsigned jc,
                                int unsigned bc, int unsigned oc);
        vec_t v;
        v.g = g; v.h = h; v.j = j; v.b = b; v.c = c;
        v.st = st; v.t = t; v.jc = jc; v.bc = bc; v.oc = oc;
        return v;
    endfunction

    vec_t vt[$];
    int unsigned exp5[4] = '{9, 2, 3, 4};

    initial begin
        // Test 2/3 vectors: {go,halt,jmp,br,clr} -> state,total,jmp,br,other after the edge.
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 1, 0, 0, 1, 2, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 0, 1, 3, 1, 1, 1));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 1, 2));
        vt.push_back(mk(0, 0, 1, 1, 0, 1, 5, 2, 1, 2));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 6, 2, 1, 3));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 7, 2, 1, 4));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 8, 2, 1, 5));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 9, 2, 1, 6));
        vt.push_back(mk(0, 1, 0, 0, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(0, 0, 1, 0, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(0, 1, 0, 1, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(0, 0, 0, 0, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(0, 1, 1, 1, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(0, 0, 0, 0, 0, 2, 10, 2, 1, 7));
        vt.push_back(mk(1, 1, 0, 0, 0, 1, 10, 2, 1, 7));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 11, 2, 1, 8));
        vt.push_back(mk(1, 0, 0, 0, 0, 1, 12, 2, 1, 9));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 13, 2, 1, 10));
        vt.push_back(mk(0, 0, 0, 0, 0, 1, 14, 2, 1, 11));
        vt.push_back(mk(0, 1, 0, 0, 0, 2, 15, 2, 1, 12));

        model_reset();
        #2;
        compare_all();
        chk("reset.state", st16, 0);
        RST = 1'b1;

        // Test 1: async reset mid-count, between edges.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, i[0], 0, 0);
        chk("pre_reset.total", t16, 4);
        #3;
        RST = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst.total", t16, 0);
        chk("async_rst.state", st16, 0);
        #2;
        RST = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        chk("idle_after_rst.total", t16, 0);

        // Tests 2 and 3 from the table.
        foreach (vt[i]) begin
            step(vt[i].g, vt[i].h, vt[i].j, vt[i].b, vt[i].c);
            chk($sformatf("vec%0d.state", i), st16, vt[i].st);
            chk($sformatf("vec%0d.total", i), t16, vt[i].t);
            chk($sformatf("vec%0d.jmp", i), j16, vt[i].jc);
            chk($sformatf("vec%0d.br", i), b16, vt[i].bc);
            chk($sformatf("vec%0d.other", i), o16, vt[i].oc);
        end

        // Test 4: saturation on the 4-bit instance.
        step(0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0, 0);
            if (i == 14) begin
                chk("sat4.total_at15", t4, 15);
                chk("sat4.flag_at15", sat4, 0);
            end
            if (i == 15) begin
                chk("sat4.total_at16", t4, 15);
                chk("sat4.other_at16", o4, 15);
                chk("sat4.flag_at16", sat4, 1);
            end
        end
        chk("sat4.flag_end", sat4, 1);
        chk("sat16.flag_end", sat16, 0);
        step(0, 0, 0, 0, 1);
        chk("sat4.clr_total", t4, 0);
        chk("sat4.clr_sat", sat4, 0);
        chk("sat4.clr_state", st4, 0);

        // Test 5: counters 9/2/3/4, then sweep sel within one cycle.
        step(1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            chk($sformatf("disp_sel%0d", s), d16, exp5[s]);
        end

        // Test 6: clr wins over go, then go alone starts.
        step(1, 0, 0, 0, 1);
        chk("clr_go.state", st16, 0);
        chk("clr_go.total", t16, 0);
        step(1, 0, 0, 0, 0);
        chk("go_after_clr.state", st16, 1);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
